rcu_clk_seq: RTL and testbench

Clock/reset bring-up sequencer for the RCU, running on the buffered low-frequency reference clock. It enables the PLL and waits for lock with a software timeout. It switches the core clock source from bypass to PLL only while every downstream reset is held, then releases the domain resets one at a time in a fixed order. It also handles PLL lock loss and software requests to return to bypass, falling back without glitching any domain.

---
 rtl/rcu_clk_seq_pkg.sv | 22 ++
 rtl/rcu_lock_sync.sv | 22 ++
 rtl/rcu_clk_seq.sv | 168 ++++++++++++++++
 tb/tb_rcu_clk_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rcu_clk_seq_pkg.sv
// Shared definitions for the RCU clock/reset bring-up sequencer:
// FSM state encoding, clock-select encoding and a small width helper.
package rcu_clk_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_SWITCH,
        ST_REL,
        ST_RUN,
        ST_DOWN
    } rcu_state_e;

    localparam logic SEL_BYPASS = 1'b0;
    localparam logic SEL_PLL    = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rcu_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
// Resets to 0 so a freshly reset sequencer never sees a stale lock.
module rcu_lock_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/rcu_clk_seq.sv
// Clock/reset bring-up sequencer: enables the PLL, waits for a settled lock,
// swaps the core clock mux under full reset, then releases domain resets in order.
module rcu_clk_seq
    import rcu_clk_seq_pkg::*;
#(
    parameter int RST_NUM       = 4,
    parameter int LOCK_TO_WIDTH = 16,
    parameter int SETTLE_CYC    = 16,
    parameter int RST_GAP       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_i,
    input  logic                     pll_lock_i,
    input  logic [LOCK_TO_WIDTH-1:0] lock_to_i,
    output logic                     pll_en_o,
    output logic                     clk_sel_o,
    output logic [RST_NUM-1:0]       rst_n_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    // The timer must also cover the full release ramp, not just lock/settle counts.
    localparam int TMR_W = max_int(max_int(LOCK_TO_WIDTH, $clog2(SETTLE_CYC) + 1),
                                   $clog2(RST_NUM * RST_GAP + 1));

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(RST_GAP - 1);
    localparam logic [TMR_W-1:0] REL_END     = TMR_W'(RST_NUM * RST_GAP);

    rcu_state_e              state_q;
    logic [TMR_W-1:0]        timer_q;
    logic                    lock_s;
    logic [LOCK_TO_WIDTH-1:0] lock_to_last;
    logic                    go_down;
    logic                    fault;

    rcu_lock_sync u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pll_lock_i),
        .q_o     (lock_s)
    );

    // A zero timeout wraps to all-ones, giving the full 2^LOCK_TO_WIDTH window.
    assign lock_to_last = lock_to_i - LOCK_TO_WIDTH'(1);

    // Fallback decisions shared by every state that may abandon the PLL path.
    always_comb begin
        go_down = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (!req_i) begin
                    go_down = 1'b1;
                end else if (!lock_s && (timer_q == TMR_W'(lock_to_last))) begin
                    go_down = 1'b1;
                    fault   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!req_i) go_down = 1'b1;
            end
            ST_REL, ST_RUN: begin
                if ((state_q == ST_RUN) || (clk_sel_o == SEL_PLL)) begin
                    if (!lock_s) begin
                        go_down = 1'b1;
                        fault   = 1'b1;
                    end else if (!req_i) begin
                        go_down = 1'b1;
                    end
                end
            end
            default: begin
                go_down = 1'b0;
                fault   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_REL;
            timer_q   <= '0;
            pll_en_o  <= 1'b0;
            clk_sel_o <= SEL_BYPASS;
            rst_n_o   <= '0;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (go_down) begin
                // Mux returns to bypass in the same edge that asserts every reset.
                state_q   <= ST_DOWN;
                timer_q   <= '0;
                pll_en_o  <= 1'b0;
                clk_sel_o <= SEL_BYPASS;
                rst_n_o   <= '0;
                busy_o    <= 1'b1;
                done_o    <= 1'b0;
                if (fault) err_o <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (req_i && !err_o) begin
                            state_q  <= ST_WAIT_LOCK;
                            timer_q  <= '0;
                            pll_en_o <= 1'b1;
                            rst_n_o  <= '0;
                            busy_o   <= 1'b1;
                        end else if (!req_i) begin
                            err_o <= 1'b0;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            state_q <= ST_SETTLE;
                            timer_q <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        if (!lock_s) begin
                            state_q <= ST_WAIT_LOCK;
                            timer_q <= '0;
                        end else if (timer_q == SETTLE_LAST) begin
                            state_q   <= ST_SWITCH;
                            timer_q   <= '0;
                            clk_sel_o <= SEL_PLL;
                        end
                    end
                    ST_SWITCH: begin
                        if (timer_q == GAP_LAST) begin
                            state_q <= ST_REL;
                            timer_q <= '0;
                        end
                    end
                    ST_REL: begin
                        for (int k = 0; k < RST_NUM; k++) begin
                            if (timer_q == TMR_W'((k + 1) * RST_GAP - 1)) rst_n_o[k] <= 1'b1;
                        end
                        if (timer_q == REL_END) begin
                            state_q <= (clk_sel_o == SEL_PLL) ? ST_RUN : ST_IDLE;
                            timer_q <= '0;
                            busy_o  <= 1'b0;
                            done_o  <= (clk_sel_o == SEL_PLL);
                        end
                    end
                    ST_RUN: begin
                        timer_q <= '0;
                    end
                    ST_DOWN: begin
                        if (timer_q == SETTLE_LAST) begin
                            state_q <= ST_REL;
                            timer_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_REL;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rcu_clk_seq.sv
// Self-checking bench for rcu_clk_seq: a table of timed input/expected-output
// records replayed through a scoreboard queue, plus an async-reset sequence.
module tb_rcu_clk_seq;

    logic        clk;
    logic        rst_n_i;
    logic        req_i;
    logic        pll_lock_i;
    logic [15:0] lock_to_i;
    logic        pll_en_o;
    logic        clk_sel_o;
    logic [3:0]  rst_n_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    typedef struct {
        bit          req;
        bit          lock;
        logic [15:0] lock_to;
        int          cycles;
        logic [8:0]  exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];
    int         num_checks = 0;
    int         num_pass   = 0;
    logic       prev_sel   = 1'b0;

    rcu_clk_seq #(
        .RST_NUM       (4),
        .LOCK_TO_WIDTH (16),
        .SETTLE_CYC    (16),
        .RST_GAP       (4)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .req_i      (req_i),
        .pll_lock_i (pll_lock_i),
        .lock_to_i  (lock_to_i),
        .pll_en_o   (pll_en_o),
        .clk_sel_o  (clk_sel_o),
        .rst_n_o    (rst_n_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any change of the clock select must be accompanied by all resets held.
    always @(posedge clk) begin
        #1;
        if (rst_n_i && (clk_sel_o !== prev_sel)) begin
            num_checks++;
            if (rst_n_o !== 4'b0000)
                $display("[TB] FAIL sel_change_under_reset: rst_n_o=%b required 0000 when clk_sel_o -> %b",
                         rst_n_o, clk_sel_o);
            else
                num_pass++;
        end
        prev_sel = clk_sel_o;
    end

    task automatic addVec(input bit req, input bit lock, input logic [15:0] lock_to,
                          input int cycles, input logic pll, input logic sel,
                          input logic [3:0] rst, input logic busy, input logic done,
                          input logic err);
        vec_t v;
        v.req     = req;
        v.lock    = lock;
        v.lock_to = lock_to;
        v.cycles  = cycles;
        v.exp     = {pll, sel, rst, busy, done, err};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        req_i      = v.req;
        pll_lock_i = v.lock;
        lock_to_i  = v.lock_to;
        exp_q.push_back(v.exp);
        repeat (v.cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [8:0] exp;
        logic [8:0] act;
        act = {pll_en_o, clk_sel_o, rst_n_o, busy_o, done_o, err_o};
        num_checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, actual %b", tag, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp)
                $display("[TB] FAIL %s: {pll,sel,rst[3:0],busy,done,err} actual %b required %b",
                         tag, act, exp);
            else
                num_pass++;
        end
    endtask

    task automatic runVectors(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("%s_vec%0d", tag, i));
        end
    endtask

    initial begin
        // Power-on release with req low: 0001/0011/0111/1111 at edges 4/8/12/16.
        addVec(0, 0, 16'd100,  3, 0, 0, 4'b0000, 1, 0, 0);
        addVec(0, 0, 16'd100,  1, 0, 0, 4'b0001, 1, 0, 0);
        addVec(0, 0, 16'd100,  4, 0, 0, 4'b0011, 1, 0, 0);
        addVec(0, 0, 16'd100,  4, 0, 0, 4'b0111, 1, 0, 0);
        addVec(0, 0, 16'd100,  4, 0, 0, 4'b1111, 1, 0, 0);
        addVec(0, 0, 16'd100,  1, 0, 0, 4'b1111, 0, 0, 0);
        // PLL bring-up, lock arriving 10 cycles after the request.
        addVec(1, 0, 16'd100,  1, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 0, 16'd100,  9, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  2, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100, 15, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 1, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  7, 1, 1, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 1, 4'b0001, 1, 0, 0);
        addVec(1, 1, 16'd100, 12, 1, 1, 4'b1111, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 1, 4'b1111, 0, 1, 0);
        // Lock loss in RUN, bypass fallback, sticky error cleared by req low.
        addVec(1, 0, 16'd100,  2, 1, 1, 4'b1111, 0, 1, 0);
        addVec(1, 0, 16'd100,  1, 0, 0, 4'b0000, 1, 0, 1);
        addVec(1, 0, 16'd100, 19, 0, 0, 4'b0000, 1, 0, 1);
        addVec(1, 0, 16'd100,  1, 0, 0, 4'b0001, 1, 0, 1);
        addVec(1, 0, 16'd100, 12, 0, 0, 4'b1111, 1, 0, 1);
        addVec(1, 0, 16'd100,  1, 0, 0, 4'b1111, 0, 0, 1);
        addVec(1, 0, 16'd100,  5, 0, 0, 4'b1111, 0, 0, 1);
        addVec(0, 0, 16'd100,  1, 0, 0, 4'b1111, 0, 0, 0);
        // Lock timeout of 20 cycles.
        addVec(1, 0, 16'd20,   1, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 0, 16'd20,  19, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 0, 16'd20,   1, 0, 0, 4'b0000, 1, 0, 1);
        addVec(1, 0, 16'd20,  32, 0, 0, 4'b1111, 1, 0, 1);
        addVec(1, 0, 16'd20,   1, 0, 0, 4'b1111, 0, 0, 1);
        addVec(1, 0, 16'd20,   4, 0, 0, 4'b1111, 0, 0, 1);
        addVec(0, 0, 16'd20,   1, 0, 0, 4'b1111, 0, 0, 0);
        // Three-cycle lock dropout during SETTLE forces a fresh settle window.
        addVec(1, 1, 16'd100,  8, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 0, 16'd100,  3, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100, 18, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 1, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100, 20, 1, 1, 4'b1111, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 1, 4'b1111, 0, 1, 0);
        addVec(0, 1, 16'd100,  1, 0, 0, 4'b0000, 1, 0, 0);
        addVec(0, 1, 16'd100, 33, 0, 0, 4'b1111, 0, 0, 0);
        // Climb back into SWITCH for the async reset sequence.
        addVec(1, 1, 16'd100, 17, 1, 0, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 1, 4'b0000, 1, 0, 0);
        addVec(1, 1, 16'd100,  1, 1, 1, 4'b0000, 1, 0, 0);

        rst_n_i    = 1'b0;
        req_i      = 1'b0;
        pll_lock_i = 1'b0;
        lock_to_i  = 16'd100;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0});
        checkOutput("reset_values");
        rst_n_i = 1'b1;

        runVectors(0, vecs.size() - 1, "main");

        // Async reset mid-cycle inside SWITCH: outputs must drop with no clock edge.
        #2;
        rst_n_i = 1'b0;
        #1;
        exp_q.push_back({1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0});
        checkOutput("async_reset_in_switch");
        req_i      = 1'b0;
        pll_lock_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        runVectors(0, 5, "post_reset");

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
